mandel_result_collector: RTL and testbench
==========================================

Name: mandel_result_collector

Overview:
- Return path of the Mandelbrot engine array.
- Engines that finish a pixel raise their result-ready flag. This block arbitrates among them round-robin, acknowledges the winner and buffers {x, y, iteration count} in a small FIFO.
- It then writes each pixel to the frame-buffer write port as a linear address plus colour index, with backpressure.
- It signals when the last pixel of the frame (x=639, y=479) has been written.

Parameters:
- NUM_PROC, 4, number of engines.
- C_ADDR_WIDTH, 3, width of engine index (>= log2(NUM_PROC)).
- ITER_WIDTH, 8, width of iteration count / colour index.
- FIFO_DEPTH, 8, result FIFO entries (power of 2, >= 2).

Ports:
- cclk  in  1  clock; all logic on rising edge.
- creset  in  1  synchronous, active-high reset.
- rdones  in  NUM_PROC  per-engine "result ready", level; held until acknowledged.
- rwords  in  NUM_PROC*(19+ITER_WIDTH)  flattened per-engine results; slice j = {x[9:0], y[8:0], iter[ITER_WIDTH-1:0]}; stable while rdones[j]=1.
- racks  out  NUM_PROC  one-hot, one-cycle acknowledge to the granted engine.
- rgrant_addr  out  C_ADDR_WIDTH  index of the engine granted this cycle (valid when |racks).
- mem_we  out  1  write request to frame buffer.
- mem_addr  out  19  linear pixel address, y*640 + x.
- mem_data  out  ITER_WIDTH  iteration count.
- mem_ready  in  1  frame buffer accepts the write this cycle.
- frame_done  out  1  one-cycle pulse after pixel (639,479) is written.
- pixel_count  out  19  pixels written since reset or since the last frame_done.

Behaviour:
- Reset (creset=1 at edge) values:
  - racks=0, rgrant_addr=0, mem_we=0, mem_addr=0, mem_data=0, frame_done=0, pixel_count=0.
  - FIFO emptied, round-robin pointer=0, hold-off mask=0.
  - Reset mid-operation discards all buffered and in-flight results. Engines still asserting rdones are re-granted normally after reset.
- Arbitration (combinational grant, registered acks):
  - Eligible set: rdones & ~holdoff.
  - Grant is issued only if the eligible set is non-empty and FIFO count < FIFO_DEPTH, evaluated from start-of-cycle count. A pop in the same cycle does not free space for a push.
  - Winner = first eligible index searching upward from the pointer, wrapping NUM_PROC-1 -> 0.
  - At the edge:
    - racks[winner] asserted for the next cycle; rgrant_addr=winner.
    - rwords slice pushed into FIFO.
    - pointer = (winner+1) mod NUM_PROC.
    - holdoff = one-hot(winner) for one cycle, so an engine is never granted in two consecutive cycles; its rdones must be low within one cycle of racks.
  - No grant leaves pointer and FIFO unchanged; racks=0.
- Output stage (one register):
  - Loads the FIFO head when FIFO is non-empty and (mem_we=0 or mem_ready=1). This pops the FIFO and sets mem_we=1.
  - mem_addr = (y<<9) + (y<<7) + x, computed on load, 19-bit unsigned.
  - mem_data = iter.
  - Transfer occurs when mem_we && mem_ready. If FIFO is empty at that point, mem_we=0 next cycle.
  - mem_addr and mem_data hold stable while mem_we=1 and mem_ready=0.
- Latency: rdones[j] rises at cycle N with FIFO empty, pointer at j and output idle:
  - cycle N+1: racks[j]=1.
  - cycle N+2: mem_we=1.
- Throughput: one grant and one write per cycle sustained with mem_ready=1.
- Frame completion:
  - On transfer of a pixel with x=639 and y=479, frame_done=1 the next cycle and pixel_count clears to 0.
  - Otherwise each transfer increments pixel_count, saturating at 307199.
  - Out-of-range coordinates (x>639 or y>479) are written unmodified; address arithmetic wraps mod 2^19.
- FIFO: full when count=FIFO_DEPTH (no grants); empty when count=0 (no loads). Simultaneous push and pop with 0 < count < FIFO_DEPTH leaves count unchanged.

Test Plan:
- Single result: rdones=0001, slice0={x=5,y=3,iter=0x2A}, mem_ready=1 -> racks=0001 one cycle later; mem_we=1 two cycles after rdones with mem_addr=1925, mem_data=0x2A; pixel_count=1.
- All engines ready together: rdones=1111 held until each ack, mem_ready=1 -> racks sequence 0001, 0010, 0100, 1000 on consecutive cycles; writes in engine order 0,1,2,3.
- Backpressure: mem_ready=0, engines continuously ready -> exactly 8 acks into the FIFO plus 1 load into the output register (9 total), then racks=0. mem_addr held stable. Release mem_ready -> 9 writes in grant order, no loss or duplication.
- Last pixel: result x=639, y=479, iter=0xFF -> mem_addr=307199; frame_done pulses one cycle after the transfer; pixel_count returns to 0.
- Hold-off and fairness: engine 2 re-raises rdones immediately after its ack while engine 3 is ready -> engine 3 granted next; engine 2 is not granted twice in a row.
- Reset mid-operation: 3 results buffered, mem_ready=0, assert creset one cycle -> mem_we=0, FIFO empty, pointer=0. Engines still ready are re-acked starting from index 0.

Source files
------------

// File: rtl/mandel_result_collector.sv
// Return path of the Mandelbrot engine array: round-robin pickup of finished pixels,
// FIFO buffering, and a backpressured frame-buffer write port with end-of-frame pulse.
module mandel_result_collector #(
  parameter int NUM_PROC     = 4,
  parameter int C_ADDR_WIDTH = 3,
  parameter int ITER_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                                cclk,
  input  logic                                creset,
  input  logic [NUM_PROC-1:0]                 rdones,
  input  logic [NUM_PROC*(19+ITER_WIDTH)-1:0] rwords,
  output logic [NUM_PROC-1:0]                 racks,
  output logic [C_ADDR_WIDTH-1:0]             rgrant_addr,
  output logic                                mem_we,
  output logic [18:0]                         mem_addr,
  output logic [ITER_WIDTH-1:0]               mem_data,
  input  logic                                mem_ready,
  output logic                                frame_done,
  output logic [18:0]                         pixel_count
);
  localparam int WORD_W = 19 + ITER_WIDTH;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [18:0] PIXEL_MAX = 19'd307199;

  logic [C_ADDR_WIDTH-1:0] rr_ptr;
  logic [NUM_PROC-1:0]     holdoff;
  logic [NUM_PROC-1:0]     eligible;
  logic [NUM_PROC-1:0]     grant_onehot;
  logic                    grant;
  logic [C_ADDR_WIDTH-1:0] winner;
  logic [WORD_W-1:0]       grant_word;

  logic [WORD_W-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    load;
  logic                    transfer;
  logic                    mem_last;

  logic [WORD_W-1:0]       head;
  logic [9:0]              head_x;
  logic [8:0]              head_y;
  logic [18:0]             head_addr;
  logic                    head_last;

  // Search upward from the pointer; the outer loop orders candidates, the inner loop
  // keeps every vector index a constant.
  always_comb begin
    eligible     = rdones & ~holdoff;
    grant        = 1'b0;
    winner       = '0;
    grant_onehot = '0;
    grant_word   = '0;
    for (int k = 0; k < NUM_PROC; k++) begin
      for (int i = 0; i < NUM_PROC; i++) begin
        if (!grant && eligible[i] && ((int'(rr_ptr) + k) % NUM_PROC) == i) begin
          grant  = 1'b1;
          winner = C_ADDR_WIDTH'(i);
        end
      end
    end
    if (count == CNT_W'(FIFO_DEPTH))
      grant = 1'b0;
    for (int i = 0; i < NUM_PROC; i++) begin
      if (winner == C_ADDR_WIDTH'(i)) begin
        grant_onehot[i] = grant;
        grant_word      = rwords[i*WORD_W +: WORD_W];
      end
    end
  end

  always_ff @(posedge cclk) begin
    if (creset) begin
      racks       <= '0;
      rgrant_addr <= '0;
      holdoff     <= '0;
      rr_ptr      <= '0;
    end else begin
      racks   <= grant_onehot;
      holdoff <= grant_onehot;
      if (grant) begin
        rgrant_addr <= winner;
        rr_ptr      <= (winner == C_ADDR_WIDTH'(NUM_PROC - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  assign transfer = mem_we & mem_ready;
  assign load     = (count != '0) && (!mem_we || mem_ready);

  // Storage needs no reset; validity is carried entirely by count and the pointers.
  always_ff @(posedge cclk) begin
    if (grant)
      fifo_mem[wr_ptr] <= grant_word;
  end

  always_ff @(posedge cclk) begin
    if (creset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant)
        wr_ptr <= wr_ptr + 1'b1;
      if (load)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(grant) - CNT_W'(load);
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign head_x    = head[WORD_W-1 -: 10];
  assign head_y    = head[ITER_WIDTH +: 9];
  assign head_addr = ({10'd0, head_y} << 9) + ({10'd0, head_y} << 7) + {9'd0, head_x};
  assign head_last = (head_x == 10'd639) && (head_y == 9'd479);

  always_ff @(posedge cclk) begin
    if (creset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_last <= 1'b0;
    end else if (load) begin
      mem_we   <= 1'b1;
      mem_addr <= head_addr;
      mem_data <= head[ITER_WIDTH-1:0];
      mem_last <= head_last;
    end else if (transfer) begin
      mem_we <= 1'b0;
    end
  end

  always_ff @(posedge cclk) begin
    if (creset) begin
      frame_done  <= 1'b0;
      pixel_count <= '0;
    end else begin
      frame_done <= transfer && mem_last;
      if (transfer) begin
        if (mem_last)
          pixel_count <= '0;
        else if (pixel_count != PIXEL_MAX)
          pixel_count <= pixel_count + 19'd1;
      end
    end
  end

endmodule

// File: tb/tb_mandel_result_collector.sv
// Bench for mandel_result_collector: queue-based engine/frame-buffer model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mandel_result_collector;
  localparam int NP = 4;
  localparam int AW = 3;
  localparam int IW = 8;
  localparam int FD = 8;
  localparam int WW = 19 + IW;

  logic              cclk = 1'b0;
  logic              creset = 1'b1;
  logic [NP-1:0]     rdones = '0;
  logic [NP*WW-1:0]  rwords = '0;
  logic [NP-1:0]     racks;
  logic [AW-1:0]     rgrant_addr;
  logic              mem_we;
  logic [18:0]       mem_addr;
  logic [IW-1:0]     mem_data;
  logic              mem_ready = 1'b0;
  logic              frame_done;
  logic [18:0]       pixel_count;

  always #5 cclk = ~cclk;

  mandel_result_collector #(
    .NUM_PROC(NP), .C_ADDR_WIDTH(AW), .ITER_WIDTH(IW), .FIFO_DEPTH(FD)
  ) dut (
    .cclk(cclk), .creset(creset), .rdones(rdones), .rwords(rwords),
    .racks(racks), .rgrant_addr(rgrant_addr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready), .frame_done(frame_done),
    .pixel_count(pixel_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Each engine holds a list of finished pixels, presenting the oldest until acked.
  logic [WW-1:0] eng_buf [NP][16];
  int            eng_head [NP];
  int            eng_tail [NP];

  // Reference model: result queue, output slot and frame counter in plain integers.
  logic [WW-1:0] m_fifo [$];
  int            m_ptr = 0;
  int            m_hold = -1;
  bit            m_we = 0;
  int            m_x = 0, m_y = 0, m_iter = 0;
  int            m_count = 0;
  bit            m_done = 0;
  logic [NP-1:0] m_racks = '0;
  int            m_gaddr = 0;
  bit            model_valid = 0;

  bit reset_next = 1'b1;
  bit ready_next = 1'b0;
  int acks = 0;
  int writes = 0;

  function automatic logic [WW-1:0] mk(input int x, input int y, input int it);
    return {10'(x), 9'(y), 8'(it)};
  endfunction

  task automatic push_eng(input int j, input int x, input int y, input int it);
    eng_buf[j][eng_tail[j]] = mk(x, y, it);
    eng_tail[j]++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    if (model_valid) begin
      check("racks", 32'(racks), 32'(m_racks));
      check("mem_we", 32'(mem_we), 32'(m_we));
      check("frame_done", 32'(frame_done), 32'(m_done));
      check("pixel_count", 32'(pixel_count), 32'(m_count));
      if (m_racks != '0)
        check("rgrant_addr", 32'(rgrant_addr), 32'(m_gaddr));
      if (m_we) begin
        check("mem_addr", 32'(mem_addr), 32'((m_y * 640 + m_x) % 524288));
        check("mem_data", 32'(mem_data), 32'(m_iter));
      end
    end
  endtask

  task automatic applyStimulus();
    creset    = reset_next;
    mem_ready = ready_next;
    for (int j = 0; j < NP; j++) begin
      if (eng_head[j] < eng_tail[j]) begin
        rdones[j] = 1'b1;
        rwords[j*WW +: WW] = eng_buf[j][eng_head[j]];
      end else begin
        rdones[j] = 1'b0;
        rwords[j*WW +: WW] = '0;
      end
    end
  endtask

  task automatic model_advance(input bit rst, input logic [NP-1:0] rd, input bit rdy);
    int win;
    int idx;
    bit xfer;
    bit do_load;
    logic [WW-1:0] w;
    if (rst) begin
      m_fifo.delete();
      m_ptr = 0; m_hold = -1; m_we = 0; m_x = 0; m_y = 0; m_iter = 0;
      m_count = 0; m_done = 0; m_racks = '0; m_gaddr = 0;
      model_valid = 1;
      return;
    end
    xfer = m_we && rdy;
    win = -1;
    if (m_fifo.size() < FD) begin
      for (int k = 0; k < NP; k++) begin
        idx = (m_ptr + k) % NP;
        if (win < 0 && rd[idx] && idx != m_hold)
          win = idx;
      end
    end
    do_load = (m_fifo.size() > 0) && (!m_we || rdy);
    m_done = 0;
    if (xfer) begin
      if (m_x == 639 && m_y == 479) begin
        m_done = 1;
        m_count = 0;
      end else if (m_count < 307199) begin
        m_count++;
      end
    end
    if (do_load) begin
      w = m_fifo.pop_front();
      m_x = int'(w[WW-1 -: 10]);
      m_y = int'(w[IW +: 9]);
      m_iter = int'(w[IW-1:0]);
      m_we = 1;
    end else if (xfer) begin
      m_we = 0;
    end
    if (win >= 0) begin
      m_fifo.push_back(eng_buf[win][eng_head[win]]);
      m_racks = NP'(1 << win);
      m_gaddr = win;
      m_ptr = (win + 1) % NP;
      m_hold = win;
    end else begin
      m_racks = '0;
      m_hold = -1;
    end
  endtask

  task automatic step();
    @(negedge cclk);
    checkOutput();
    acks += $countones(racks);
    for (int j = 0; j < NP; j++)
      if (m_racks[j]) eng_head[j]++;
    applyStimulus();
    if (mem_we && mem_ready && !creset)
      writes++;
    model_advance(creset, rdones, mem_ready);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    for (int j = 0; j < NP; j++) begin
      eng_head[j] = 0;
      eng_tail[j] = 0;
    end
    reset_next = 1'b1;
    step();
    reset_next = 1'b0;
    acks = 0;
    writes = 0;
  endtask

  initial begin
    for (int j = 0; j < NP; j++) begin
      eng_head[j] = 0;
      eng_tail[j] = 0;
    end

    $display("[TB] reset values");
    do_reset();
    step();
    check("rst racks", 32'(racks), 0);
    check("rst rgrant_addr", 32'(rgrant_addr), 0);
    check("rst mem_we", 32'(mem_we), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst mem_data", 32'(mem_data), 0);
    check("rst frame_done", 32'(frame_done), 0);
    check("rst pixel_count", 32'(pixel_count), 0);

    $display("[TB] single result");
    do_reset();
    ready_next = 1'b1;
    push_eng(0, 5, 3, 8'h2A);
    step();
    step();
    check("single racks", 32'(racks), 32'h1);
    step();
    check("single mem_we", 32'(mem_we), 1);
    check("single mem_addr", 32'(mem_addr), 1925);
    check("single mem_data", 32'(mem_data), 32'h2A);
    step();
    check("single pixel_count", 32'(pixel_count), 1);
    steps(2);

    $display("[TB] all engines ready");
    do_reset();
    ready_next = 1'b1;
    for (int j = 0; j < NP; j++) push_eng(j, j * 10, j, 8'h10 + j);
    step();
    step();
    check("rr racks0", 32'(racks), 32'h1);
    step();
    check("rr racks1", 32'(racks), 32'h2);
    check("rr data0", 32'(mem_data), 32'h10);
    step();
    check("rr racks2", 32'(racks), 32'h4);
    check("rr data1", 32'(mem_data), 32'h11);
    step();
    check("rr racks3", 32'(racks), 32'h8);
    check("rr data2", 32'(mem_data), 32'h12);
    step();
    check("rr data3", 32'(mem_data), 32'h13);
    steps(3);

    $display("[TB] backpressure");
    do_reset();
    ready_next = 1'b0;
    for (int j = 0; j < NP; j++)
      for (int k = 0; k < 4; k++) push_eng(j, 100 + j, 10 + k, j * 16 + k);
    steps(14);
    check("bp acks", 32'(acks), 9);
    check("bp racks idle", 32'(racks), 0);
    check("bp held addr", 32'(mem_addr), 6500);
    check("bp held data", 32'(mem_data), 0);
    check("bp writes", 32'(writes), 0);
    ready_next = 1'b1;
    steps(40);
    check("bp total writes", 32'(writes), 16);
    check("bp pixel_count", 32'(pixel_count), 16);

    $display("[TB] last pixel");
    do_reset();
    ready_next = 1'b1;
    push_eng(0, 1, 1, 1);
    push_eng(0, 639, 479, 8'hFF);
    steps(5);
    check("last mem_addr", 32'(mem_addr), 307199);
    check("last mem_data", 32'(mem_data), 32'hFF);
    check("last count before", 32'(pixel_count), 1);
    step();
    check("last frame_done", 32'(frame_done), 1);
    check("last pixel_count", 32'(pixel_count), 0);
    step();
    check("last frame_done off", 32'(frame_done), 0);
    steps(2);

    $display("[TB] hold-off and fairness");
    do_reset();
    ready_next = 1'b1;
    push_eng(2, 20, 20, 1);
    push_eng(2, 21, 20, 2);
    push_eng(3, 30, 30, 3);
    step();
    step();
    check("hold racks e2", 32'(racks), 32'h4);
    step();
    check("hold racks e3", 32'(racks), 32'h8);
    step();
    check("hold racks e2 again", 32'(racks), 32'h4);
    steps(4);

    $display("[TB] reset mid-operation");
    do_reset();
    ready_next = 1'b0;
    push_eng(0, 1, 2, 8'hA0);
    push_eng(0, 2, 2, 8'hA1);
    push_eng(1, 3, 2, 8'hB0);
    push_eng(2, 4, 2, 8'hC0);
    push_eng(3, 5, 2, 8'hD0);
    steps(3);
    reset_next = 1'b1;
    step();
    reset_next = 1'b0;
    step();
    check("midrst mem_we", 32'(mem_we), 0);
    check("midrst racks", 32'(racks), 0);
    step();
    check("midrst reack e0", 32'(racks), 32'h1);
    step();
    check("midrst reack e3", 32'(racks), 32'h8);
    ready_next = 1'b1;
    steps(8);
    check("midrst pixel_count", 32'(pixel_count), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
